// File: rtl/m_neg_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_neg_arbiter_pkg : shared types and defaults for the negation arbiter   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package m_neg_arbiter_pkg;

    localparam int unsigned c_BITLEN_DEFAULT  = 5;
    localparam int unsigned c_TIMEOUT_DEFAULT = 32;
    localparam int unsigned c_CNT_W           = 8;

    typedef logic [1:0] grant_t;

    typedef enum logic [1:0] {
        c_ST_IDLE      = 2'd0,
        c_ST_ISSUE     = 2'd1,
        c_ST_WAIT_DONE = 2'd2,
        c_ST_RESP      = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/m_neg_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_rr_pick2 : two-way round-robin pick, one-hot grant                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module m_rr_pick2
    import m_neg_arbiter_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  logic   i_last_served,
    output grant_t o_grant
);

    // On contention the requester that was not served last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = i_last_served ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_neg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_neg_arbiter : round-robin arbiter sharing one 2's-complement unit      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module m_neg_arbiter
    import m_neg_arbiter_pkg::*;
#(
    parameter int unsigned BITLEN  = c_BITLEN_DEFAULT,
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [BITLEN-1:0] req0_data,
    input  logic [BITLEN-1:0] req1_data,
    output logic              grant0,
    output logic              grant1,
    output logic [BITLEN-1:0] rsp_data,
    output logic              rsp0_valid_pulse,
    output logic              rsp1_valid_pulse,
    output logic              rsp_err,
    output logic [BITLEN-1:0] tog_in,
    output logic              tog_in_valid_pulse,
    input  logic              mod_busy,
    input  logic [BITLEN-1:0] tog_out,
    input  logic              tog_out_valid_pulse,
    output logic              arb_busy
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    arb_state_e          r_state_q,    w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,      w_cnt_d;
    grant_t              r_grant_q,    w_grant_d;
    logic [BITLEN-1:0]   r_tog_in_q,   w_tog_in_d;
    logic [BITLEN-1:0]   r_rsp_data_q, w_rsp_data_d;
    logic                r_err_q,      w_err_d;
    logic                r_last_q,     w_last_d;
    grant_t              w_pick;

    m_rr_pick2 u_pick (
        .i_req0        (req0),
        .i_req1        (req1),
        .i_last_served (r_last_q),
        .o_grant       (w_pick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q    <= c_ST_IDLE;
            r_cnt_q      <= '0;
            r_grant_q    <= 2'b00;
            r_tog_in_q   <= '0;
            r_rsp_data_q <= '0;
            r_err_q      <= 1'b0;
            r_last_q     <= 1'b1;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_grant_q    <= w_grant_d;
            r_tog_in_q   <= w_tog_in_d;
            r_rsp_data_q <= w_rsp_data_d;
            r_err_q      <= w_err_d;
            r_last_q     <= w_last_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_grant_d    = r_grant_q;
        w_tog_in_d   = r_tog_in_q;
        w_rsp_data_d = r_rsp_data_q;
        w_err_d      = r_err_q;
        w_last_d     = r_last_q;
        case (r_state_q)
            c_ST_IDLE: begin
                w_cnt_d = '0;
                // The unit has no reset of its own, so never issue while it is busy.
                if ((req0 || req1) && !mod_busy) begin
                    w_grant_d  = w_pick;
                    w_tog_in_d = w_pick[1] ? req1_data : req0_data;
                    w_err_d    = 1'b0;
                    w_state_d  = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_cnt_d   = '0;
                w_state_d = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (tog_out_valid_pulse) begin
                    w_rsp_data_d = tog_out;
                    w_err_d      = 1'b0;
                    w_state_d    = c_ST_RESP;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_rsp_data_d = '0;
                    w_err_d      = 1'b1;
                    w_state_d    = c_ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            c_ST_RESP: begin
                w_last_d  = r_grant_q[1];
                w_grant_d = 2'b00;
                w_cnt_d   = '0;
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_grant_d = 2'b00;
                w_cnt_d   = '0;
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are forced low combinationally so they are quiet for the whole reset window.
    assign grant0             = !reset && r_grant_q[0];
    assign grant1             = !reset && r_grant_q[1];
    assign tog_in             = reset ? '0 : r_tog_in_q;
    assign tog_in_valid_pulse = !reset && (r_state_q == c_ST_ISSUE);
    assign rsp0_valid_pulse   = !reset && (r_state_q == c_ST_RESP) && r_grant_q[0];
    assign rsp1_valid_pulse   = !reset && (r_state_q == c_ST_RESP) && r_grant_q[1];
    assign rsp_err            = !reset && (r_state_q == c_ST_RESP) && r_err_q;
    assign rsp_data           = reset ? '0 : r_rsp_data_q;
    assign arb_busy           = !reset && (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_m_neg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_m_neg_arbiter : bench for m_neg_arbiter with a transaction-level model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_m_neg_arbiter;

    localparam int W   = 5;
    localparam int TMO = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         grant0, grant1;
    logic [W-1:0] rsp_data;
    logic         rsp0_valid_pulse, rsp1_valid_pulse, rsp_err;
    logic [W-1:0] tog_in;
    logic         tog_in_valid_pulse;
    logic         mod_busy = 1'b0;
    logic [W-1:0] tog_out = '0;
    logic         tog_out_valid_pulse = 1'b0;
    logic         arb_busy;

    int tests = 0;
    int fails = 0;
    int last_served = 1;

    m_neg_arbiter #(.BITLEN(W), .TIMEOUT(TMO)) dut (
        .clock               (clock),
        .reset               (reset),
        .req0                (req0),
        .req1                (req1),
        .req0_data           (req0_data),
        .req1_data           (req1_data),
        .grant0              (grant0),
        .grant1              (grant1),
        .rsp_data            (rsp_data),
        .rsp0_valid_pulse    (rsp0_valid_pulse),
        .rsp1_valid_pulse    (rsp1_valid_pulse),
        .rsp_err             (rsp_err),
        .tog_in              (tog_in),
        .tog_in_valid_pulse  (tog_in_valid_pulse),
        .mod_busy            (mod_busy),
        .tog_out             (tog_out),
        .tog_out_valid_pulse (tog_out_valid_pulse),
        .arb_busy            (arb_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        chk("exclusive", 32'((grant0 & grant1) | (rsp0_valid_pulse & rsp1_valid_pulse)), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, grant0, grant1, rsp0_valid_pulse, rsp1_valid_pulse, rsp_err,
                tog_in_valid_pulse, arb_busy, 5'd0, rsp_data, tog_in};
    endfunction

    // One full transaction: arbitration, issue, unit reply after lat cycles
    // (lat < 0 means the unit never answers), response and return to idle.
    task automatic run_txn(input logic a0, input logic a1, input logic [W-1:0] d0,
                           input logic [W-1:0] d1, input int lat, input int busy_n,
                           input logic drop);
        int           win;
        int           n;
        int           exp_n;
        int           exp_d;
        logic         timeout;
        logic         stable;
        logic         stray;
        logic [W-1:0] wd;
        win     = (a0 && a1) ? ((last_served == 1) ? 0 : 1) : (a1 ? 1 : 0);
        wd      = (win == 1) ? d1 : d0;
        timeout = (lat < 0) || (lat >= TMO);
        exp_n   = timeout ? TMO : lat + 1;
        exp_d   = timeout ? 0 : (((1 << W) - int'(wd)) % (1 << W));
        req0 = a0; req1 = a1; req0_data = d0; req1_data = d1;
        mod_busy = (busy_n > 0);
        for (int i = 0; i < busy_n; i++) begin
            step();
            chk("busy_gate", 32'({arb_busy, tog_in_valid_pulse}), 32'd0);
        end
        mod_busy = 1'b0;
        step();
        chk("issue_pulse", 32'(tog_in_valid_pulse), 32'd1);
        chk("issue_data", 32'(tog_in), 32'(wd));
        chk("issue_grant", 32'({grant1, grant0}), (win == 1) ? 32'd2 : 32'd1);
        if (drop) begin
            if (win == 1) req1 = 1'b0; else req0 = 1'b0;
        end
        step();
        chk("issue_one_cycle", 32'(tog_in_valid_pulse), 32'd0);
        n = 0; stable = 1'b1; stray = 1'b0;
        while (n < TMO + 4) begin
            if (n == lat) begin
                tog_out = ~tog_in + 1'b1;
                tog_out_valid_pulse = 1'b1;
            end
            step();
            n++;
            tog_out_valid_pulse = 1'b0;
            if (tog_in !== wd) stable = 1'b0;
            if (rsp0_valid_pulse || rsp1_valid_pulse) break;
            if (rsp_err) stray = 1'b1;
        end
        chk("rsp_latency", 32'(n), 32'(exp_n));
        chk("rsp_pulse", 32'({rsp1_valid_pulse, rsp0_valid_pulse}), (win == 1) ? 32'd2 : 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("rsp_err", 32'(rsp_err), 32'(timeout));
        chk("tog_in_stable", 32'(stable), 32'd1);
        chk("no_early_err", 32'(stray), 32'd0);
        last_served = win;
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk("back_to_idle", 32'({arb_busy, grant1, grant0, rsp1_valid_pulse,
                                rsp0_valid_pulse, rsp_err}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int lat;
        step();
        chk("reset_outputs", all_outs(), 32'd0);
        step();
        chk("reset_outputs_hold", all_outs(), 32'd0);
        reset = 1'b0;
        step();
        chk("post_reset_idle", 32'(arb_busy), 32'd0);

        run_txn(1'b1, 1'b0, 5'b00011, 5'd0, 2, 0, 1'b0);

        run_txn(1'b1, 1'b1, 5'd1, 5'd2, 1, 0, 1'b0);
        run_txn(1'b0, 1'b1, 5'd1, 5'd2, 0, 0, 1'b0);
        run_txn(1'b1, 1'b1, 5'd1, 5'd2, 3, 0, 1'b0);
        run_txn(1'b1, 1'b1, 5'd7, 5'd9, 1, 0, 1'b0);

        run_txn(1'b1, 1'b0, 5'd6, 5'd0, -1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 5'd4, 5'd0, 1, 0, 1'b0);

        tog_out = 5'd21;
        tog_out_valid_pulse = 1'b1;
        step();
        tog_out_valid_pulse = 1'b0;
        chk("stray_ignored", 32'({arb_busy, grant1, grant0, rsp1_valid_pulse,
                                 rsp0_valid_pulse, rsp_err}), 32'd0);
        step();
        chk("stray_still_idle", 32'({arb_busy, rsp1_valid_pulse, rsp0_valid_pulse}), 32'd0);

        run_txn(1'b0, 1'b1, 5'd0, 5'b10000, 3, 0, 1'b1);

        req0 = 1'b1; req0_data = 5'd13;
        step();
        step();
        step();
        step();
        chk("abort_in_wait", 32'(arb_busy), 32'd1);
        reset = 1'b1;
        mod_busy = 1'b1;
        #1;
        chk("reset_mid_outputs", all_outs(), 32'd0);
        step();
        chk("reset_edge_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        req0 = 1'b0;
        last_served = 1;
        step();
        chk("abort_no_rsp", 32'({arb_busy, rsp1_valid_pulse, rsp0_valid_pulse, rsp_err}), 32'd0);
        run_txn(1'b1, 1'b1, 5'd10, 5'd11, 2, 4, 1'b0);

        for (int k = 0; k < 24; k++) begin
            a   = int'($urandom_range(1, 3));
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 9));
            run_txn(a[0], a[1], W'($urandom), W'($urandom), lat,
                    int'($urandom_range(0, 2)), (a != 3) && ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
